cache_miss_ctrl: RTL and testbench
==================================

// Module: cache_miss_ctrl
// PURPOSE
// - Read-side controller that sits directly upstream of the block-addressable read-only cache.
// - Accepts block-index read requests from a consumer (e.g. BVH/triangle fetch).
// - Looks up the cache; on a hit, returns the cached block.
// - On a miss, issues an Avalon-MM read to SDRAM, fills the cache, and returns the fetched block.
// - Serves one request in flight; the cache remains a passive store that this block drives.
// PARAMETERS
// - SIZE_BLOCK  32  block width in bits; equals the cache block width and the memory data width
// - BIT_TOTAL   24  block-index width; equals the cache address width
// - BYTE_ADDR   1   1: o_mem_addr = {index, clog2(SIZE_BLOCK/8) zero bits}; 0: o_mem_addr = index
// PORTS
// - i_clk               in   1          clock
// - i_rst               in   1          reset, synchronous active-high
// - i_req_valid         in   1          request valid
// - o_req_ready         out  1          high only in IDLE
// - i_req_addr          in   BIT_TOTAL  block index
// - o_resp_valid        out  1          response valid
// - i_resp_ready        in   1          consumer accepts response
// - o_resp_data         out  SIZE_BLOCK  block data
// - o_cache_en          out  1          to cache i_en
// - o_cache_wrt         out  1          to cache i_wrt
// - o_cache_addr        out  BIT_TOTAL  to cache i_addr
// - o_cache_data        out  SIZE_BLOCK  to cache i_data
// - i_cache_data        in   SIZE_BLOCK  from cache o_data; registered, valid 1 cycle after en
// - i_cache_success     in   1          from cache o_success; hit/write-ack
// - o_mem_read          out  1          Avalon read
// - o_mem_addr          out  MAW        MAW = BIT_TOTAL + (BYTE_ADDR ? clog2(SIZE_BLOCK/8) : 0)
// - i_mem_waitrequest   in   1          Avalon waitrequest
// - i_mem_readdatavalid in   1          Avalon readdatavalid
// - i_mem_readdata      in   SIZE_BLOCK  Avalon readdata
// BEHAVIOUR
// - Single clock; reset is synchronous and active-high.
// - Reset: state=IDLE. o_req_ready=1, o_resp_valid=0, o_resp_data=0, o_cache_en=0, o_cache_wrt=0, o_mem_read=0; address/data regs=0.
// - Reset mid-operation: abandon the request and drop o_mem_read immediately.
// - readdatavalid outside MEM_WAIT is ignored, so late data from an aborted read is dropped.
// - IDLE: on i_req_valid & o_req_ready, latch addr -> LOOKUP.
// - LOOKUP (1 cycle): cache_en=1, wrt=0, addr=latched -> CHECK.
// - CHECK: if i_cache_success, capture i_cache_data -> RESP (hit latency: accept + 3 cycles to resp_valid).
//   Otherwise -> MEM_REQ.
// - MEM_REQ: hold o_mem_read=1 and o_mem_addr stable while i_mem_waitrequest=1.
//   On a cycle with read=1 & waitrequest=0 -> MEM_WAIT.
// - MEM_WAIT: on readdatavalid, capture readdata -> FILL.
// - FILL (1 cycle): cache_en=1, wrt=1, data=captured -> RESP. The cache write-ack is not waited on.
// - RESP: o_resp_valid=1, o_resp_data stable until i_resp_ready. On the handshake cycle -> IDLE.
//   The next request is accepted no earlier than the following cycle (no bypass).
// - Only one outstanding memory read ever; burstcount fixed at 1 (not a port).
// - o_cache_en is high only in LOOKUP/FILL. o_mem_read is high only in MEM_REQ.
// - The same index requested twice back-to-back: the second request must hit.
// - Index wrap: index 2^BIT_TOTAL-1 is legal. The address shift is done in MAW width, so there is no truncation.
// CONFIGURATION
// - CACHE_MISS_STATS_EN defined: adds outputs o_stat_hits and o_stat_misses, 32b each.
//   hits increments on CHECK&success; misses increments on CHECK&!success.
//   Both saturate at 2^32-1 and reset to 0 on i_rst.
// - Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
// - Shared package cache_pkg holds:
//   - typedef enum logic [2:0] miss_state_t {IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP}
//   - localparam default block/addr widths shared with the cache
// - No sub-module: one FSM plus datapath registers; stats counters inline under the macro.
// - The cache is instantiated by the parent, alongside this block.
// TESTING
// - Bench: this block + real cache (BIT_INDEX=8, WAY=2) + Avalon memory model.
//   Memory model: mem[i] = i ^ 32'hA5A5_0000, random 0-3 waitrequest cycles, 2-6 cycle read latency.
// - Cold miss: req 0x000010 -> exactly one mem read at addr 0x000040, then resp 0xA5A5_0010.
// - Re-hit: req 0x000010 again -> no o_mem_read, resp_valid exactly 3 cycles after accept, data 0xA5A5_0010.
// - Set conflict: req 0x000110 then 0x000210 (same set 0x10, 2 ways), then 0x000010.
//   All responses correct; 0x000010 must miss again under NMRU (3 fills into 2 ways).
// - Backpressure: hold i_resp_ready=0 for 10 cycles -> o_resp_valid held, data stable, o_req_ready=0.
// - Reset during MEM_WAIT: pulse i_rst; the model returns readdatavalid 2 cycles later.
//   Required: o_resp_valid stays 0; the next req 0x000020 returns 0xA5A5_0020.
// - Top index 0xFFFFFF -> o_mem_addr 0x3FFFFFC, resp 0xA55A_FFFF.
//   With the macro defined after the tests above: hits/misses counters match scoreboard totals.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and default geometry for the read-only block cache and its miss controller.
package cache_pkg;

    localparam int CACHE_SIZE_BLOCK = 32;
    localparam int CACHE_BIT_TOTAL  = 24;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        MEM_REQ,
        MEM_WAIT,
        FILL,
        RESP
    } miss_state_t;

endpackage

// File: rtl/cache_miss_ctrl.sv
// Read-side miss controller: cache lookup, Avalon-MM refill on miss, single request in flight.
// Optional hit/miss counters are enabled by defining CACHE_MISS_STATS_EN.
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int SIZE_BLOCK  = CACHE_SIZE_BLOCK,
    parameter int BIT_TOTAL   = CACHE_BIT_TOTAL,
    parameter int BYTE_ADDR   = 1,
    localparam int MAW        = BIT_TOTAL + ((BYTE_ADDR != 0) ? $clog2(SIZE_BLOCK / 8) : 0)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [BIT_TOTAL-1:0]  i_req_addr,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [SIZE_BLOCK-1:0] o_resp_data,
    output logic                  o_cache_en,
    output logic                  o_cache_wrt,
    output logic [BIT_TOTAL-1:0]  o_cache_addr,
    output logic [SIZE_BLOCK-1:0] o_cache_data,
    input  logic [SIZE_BLOCK-1:0] i_cache_data,
    input  logic                  i_cache_success,
    output logic                  o_mem_read,
    output logic [MAW-1:0]        o_mem_addr,
    input  logic                  i_mem_waitrequest,
    input  logic                  i_mem_readdatavalid,
    input  logic [SIZE_BLOCK-1:0] i_mem_readdata
`ifdef CACHE_MISS_STATS_EN
    ,
    output logic [31:0]           o_stat_hits,
    output logic [31:0]           o_stat_misses
`endif
);

    localparam int ADDR_SHIFT = MAW - BIT_TOTAL;

    miss_state_t           state_q, state_d;
    logic [BIT_TOTAL-1:0]  addr_q, addr_d;
    logic [SIZE_BLOCK-1:0] data_q, data_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // data_q carries the hit data or the refill data; it feeds both the fill write and the response.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    addr_d  = i_req_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: state_d = CHECK;
            CHECK: begin
                if (i_cache_success) begin
                    data_d  = i_cache_data;
                    state_d = RESP;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (!i_mem_waitrequest) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (i_mem_readdatavalid) begin
                    data_d  = i_mem_readdata;
                    state_d = FILL;
                end
            end
            FILL: state_d = RESP;
            RESP: begin
                if (i_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_req_ready  = (state_q == IDLE);
    assign o_resp_valid = (state_q == RESP);
    assign o_resp_data  = data_q;
    assign o_cache_en   = (state_q == LOOKUP) || (state_q == FILL);
    assign o_cache_wrt  = (state_q == FILL);
    assign o_cache_addr = addr_q;
    assign o_cache_data = data_q;
    assign o_mem_read   = (state_q == MEM_REQ);
    // Widen before shifting so the top index keeps all its bits.
    assign o_mem_addr   = MAW'(addr_q) << ADDR_SHIFT;

`ifdef CACHE_MISS_STATS_EN
    logic [31:0] hits_q, misses_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state_q == CHECK) begin
            if (i_cache_success) begin
                if (hits_q != '1) hits_q <= hits_q + 32'd1;
            end else begin
                if (misses_q != '1) misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign o_stat_hits   = hits_q;
    assign o_stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl with a 2-way NMRU cache model and an Avalon-MM memory model.
module tb_cache_miss_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        cache_en, cache_wrt;
    logic [23:0] cache_addr;
    logic [31:0] cache_wdata;
    logic [31:0] cache_rdata = '0;
    logic        cache_success = 1'b0;
    logic        mem_read;
    logic [25:0] mem_addr;
    logic        mem_waitreq;
    logic        mem_rdv = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef CACHE_MISS_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    cache_miss_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_data(resp_data),
        .o_cache_en(cache_en), .o_cache_wrt(cache_wrt), .o_cache_addr(cache_addr),
        .o_cache_data(cache_wdata), .i_cache_data(cache_rdata), .i_cache_success(cache_success),
        .o_mem_read(mem_read), .o_mem_addr(mem_addr), .i_mem_waitrequest(mem_waitreq),
        .i_mem_readdatavalid(mem_rdv), .i_mem_readdata(mem_rdata)
`ifdef CACHE_MISS_STATS_EN
        , .o_stat_hits(stat_hits), .o_stat_misses(stat_misses)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- cache model: 256 sets x 2 ways, NMRU victim ----------------
    logic        c_valid [256][2];
    logic [15:0] c_tag   [256][2];
    logic [31:0] c_data  [256][2];
    logic        c_mru   [256];

    initial begin
        for (int s = 0; s < 256; s++) begin
            c_valid[s][0] = 1'b0; c_valid[s][1] = 1'b0; c_mru[s] = 1'b0;
            c_tag[s][0] = '0; c_tag[s][1] = '0; c_data[s][0] = '0; c_data[s][1] = '0;
        end
    end

    always @(posedge clk) begin
        logic [7:0]  set;
        logic [15:0] tag;
        logic        vic;
        set = cache_addr[7:0];
        tag = cache_addr[23:8];
        cache_success <= 1'b0;
        if (cache_en && !cache_wrt) begin
            for (int w = 0; w < 2; w++) begin
                if (c_valid[set][w] && c_tag[set][w] == tag) begin
                    cache_success <= 1'b1;
                    cache_rdata   <= c_data[set][w];
                    c_mru[set]    <= w[0];
                end
            end
        end else if (cache_en && cache_wrt) begin
            if (!c_valid[set][0])      vic = 1'b0;
            else if (!c_valid[set][1]) vic = 1'b1;
            else                       vic = ~c_mru[set];
            c_valid[set][vic] <= 1'b1;
            c_tag[set][vic]   <= tag;
            c_data[set][vic]  <= cache_wdata;
            c_mru[set]        <= vic;
            cache_success     <= 1'b1;
        end
    end

    // ---------------- Avalon memory model ----------------
    int          wait_left = 0;
    int          lat_cnt = 0;
    int          force_lat = 0;
    int          rd_count = 0;
    int          rd_cycles = 0;
    int          rdv_count = 0;
    int          addr_err = 0;
    logic        pend = 1'b0;
    logic [25:0] pend_addr = '0;
    logic [25:0] last_addr = '0;
    logic [25:0] held_addr = '0;
    logic        was_waiting = 1'b0;

    assign mem_waitreq = (wait_left != 0);

    always @(posedge clk) begin
        mem_rdv <= 1'b0;
        if (pend) begin
            if (lat_cnt <= 1) begin
                mem_rdv   <= 1'b1;
                mem_rdata <= {8'h00, pend_addr[25:2]} ^ 32'hA5A5_0000;
                pend      <= 1'b0;
                rdv_count <= rdv_count + 1;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
        if (mem_read) rd_cycles <= rd_cycles + 1;
        if (mem_read && mem_waitreq) begin
            if (was_waiting && mem_addr != held_addr) addr_err <= addr_err + 1;
            was_waiting <= 1'b1;
            held_addr   <= mem_addr;
            wait_left   <= wait_left - 1;
        end else begin
            was_waiting <= 1'b0;
        end
        if (mem_read && !mem_waitreq) begin
            pend      <= 1'b1;
            pend_addr <= mem_addr;
            last_addr <= mem_addr;
            lat_cnt   <= (force_lat != 0) ? force_lat : int'($urandom_range(2, 6));
            wait_left <= int'($urandom_range(0, 3));
            rd_count  <= rd_count + 1;
        end
    end

    // ---------------- scoreboard helpers ----------------
    int sb_hits = 0;
    int sb_misses = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic [23:0] addr, input bit exp_hit, input int hold);
        logic [31:0] exp_d;
        logic [25:0] exp_maddr;
        int          rd0, cyc0, cyc;
        exp_q.push_back({8'h00, addr} ^ 32'hA5A5_0000);
        exp_maddr = {addr, 2'b00};
        @(negedge clk);
        check({tag, "/req_ready"}, 64'(req_ready), 64'd1);
        rd0  = rd_count;
        cyc0 = rd_cycles;
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "/resp_valid"}, 64'(resp_valid), 64'd1);
        if (exp_hit) begin
            check({tag, "/hit_latency"}, 64'(cyc), 64'd3);
            check({tag, "/read_cycles"}, 64'(rd_cycles - cyc0), 64'd0);
            sb_hits++;
        end else begin
            check({tag, "/mem_reads"}, 64'(rd_count - rd0), 64'd1);
            check({tag, "/mem_addr"}, 64'(last_addr), 64'(exp_maddr));
            sb_misses++;
        end
        exp_d = exp_q.pop_front();
        check({tag, "/resp_data"}, 64'(resp_data), 64'(exp_d));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "/bp_valid"}, 64'(resp_valid), 64'd1);
            check({tag, "/bp_data"}, 64'(resp_data), 64'(exp_d));
            check({tag, "/bp_req_ready"}, 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, "/resp_done"}, 64'(resp_valid), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rd0, rdv0, cyc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset/req_ready", 64'(req_ready), 64'd1);
        check("reset/resp_valid", 64'(resp_valid), 64'd0);
        check("reset/resp_data", 64'(resp_data), 64'd0);
        check("reset/cache_en", 64'(cache_en), 64'd0);
        check("reset/cache_wrt", 64'(cache_wrt), 64'd0);
        check("reset/mem_read", 64'(mem_read), 64'd0);
        check("reset/mem_addr", 64'(mem_addr), 64'd0);

        do_req("cold_miss", 24'h000010, 1'b0, 0);
        do_req("re_hit", 24'h000010, 1'b1, 0);
        do_req("conflict_a", 24'h000110, 1'b0, 0);
        do_req("conflict_b", 24'h000210, 1'b0, 0);
        do_req("conflict_evicted", 24'h000010, 1'b0, 0);
        do_req("backpressure", 24'h000010, 1'b1, 10);

        // Reset while the refill read is outstanding; data arrives two cycles after reset.
        force_lat = 4;
        rd0 = rd_count;
        rdv0 = rdv_count;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 24'h000030;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (rd_count == rd0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_wait/accepted", 64'(rd_count - rd0), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_wait/mem_read", 64'(mem_read), 64'd0);
        check("rst_wait/req_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_wait/resp_valid", 64'(resp_valid), 64'd0);
            check("rst_wait/cache_en", 64'(cache_en), 64'd0);
        end
        check("rst_wait/late_rdv", 64'(rdv_count - rdv0), 64'd1);
        force_lat = 0;
        sb_hits = 0;
        sb_misses = 0;

        do_req("after_rst", 24'h000020, 1'b0, 0);
        do_req("top_index", 24'hFFFFFF, 1'b0, 0);
        check("top_index/mem_addr_full", 64'(last_addr), 64'h3FF_FFFC);
        do_req("top_index_hit", 24'hFFFFFF, 1'b1, 0);
        do_req("after_rst_hit", 24'h000020, 1'b1, 0);

        check("mem_addr_stable", 64'(addr_err), 64'd0);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
`ifdef CACHE_MISS_STATS_EN
        check("stats/hits", 64'(stat_hits), 64'(sb_hits));
        check("stats/misses", 64'(stat_misses), 64'(sb_misses));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog so a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
